// File: rtl/lut_arb_pkg.sv
// Shared types and constants for the LUT AND-reduction arbiter block.
// Optional feature macro: LUT_ARB_RR_EN (round-robin arbitration).
package lut_arb_pkg;

    localparam int WIDTH     = 8;
    localparam int MAX_WIDTH = 16;
    localparam int NREQ      = 2;

    typedef logic [$clog2(NREQ)-1:0] req_id_t;

    // Operands are zero-extended to MAX_WIDTH; padding bits carry mask 0 so they never affect the result.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] data;
        logic [MAX_WIDTH-1:0] mask;
        req_id_t              id;
    } s1_payload_t;

    function automatic logic masked_and(input logic [MAX_WIDTH-1:0] data,
                                        input logic [MAX_WIDTH-1:0] mask);
        return &(data | ~mask);
    endfunction

endpackage

// File: rtl/lut_and_arbiter_if.sv
// Request/response bundle between the two requesters and lut_and_arbiter.
// Optional feature macro: LUT_ARB_RR_EN (affects arbitration only).
interface lut_and_arbiter_if #(
    parameter int WIDTH = lut_arb_pkg::WIDTH
);
    // Handshake: request i transfers on a rising edge where req_valid[i] & req_ready[i];
    // req_ready is combinational from req_valid, so req_valid must not depend on req_ready.
    // rsp_valid is a one-cycle pulse with no backpressure; rsp_result is qualified by it.
    logic [lut_arb_pkg::NREQ-1:0] req_valid;
    logic [lut_arb_pkg::NREQ-1:0] req_ready;
    logic [WIDTH-1:0]             req_data0;
    logic [WIDTH-1:0]             req_data1;
    logic [WIDTH-1:0]             req_mask0;
    logic [WIDTH-1:0]             req_mask1;
    logic [lut_arb_pkg::NREQ-1:0] rsp_valid;
    logic                         rsp_result;

    modport master (
        output req_valid, req_data0, req_data1, req_mask0, req_mask1,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_data0, req_data1, req_mask0, req_mask1,
        output req_ready, rsp_valid, rsp_result
    );

endinterface

// File: rtl/lut_arb_rr.sv
// Two-requester arbiter: one-hot grant from valid, combinational.
// LUT_ARB_RR_EN selects round-robin with a pointer register; otherwise requester 0 has fixed priority.
module lut_arb_rr
    import lut_arb_pkg::*;
(
`ifdef LUT_ARB_RR_EN
    input  logic            clk,
`endif
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant
);

`ifdef LUT_ARB_RR_EN
    req_id_t ptr;

    always_comb begin
        grant = '0;
        if (!rst) begin
            if (valid == 2'b11) grant[ptr] = 1'b1;
            else                grant = valid;
        end
    end

    // Pointer moves to the requester that was not just served.
    always_ff @(posedge clk) begin
        if (rst)         ptr <= '0;
        else if (|grant) ptr <= grant[0];
    end
`else
    always_comb begin
        grant = '0;
        if (!rst) begin
            if (valid[0])      grant = 2'b01;
            else if (valid[1]) grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/lut_and_arbiter.sv
// Arbitrates two requesters into a 2-stage pipeline computing AND over (data | ~mask).
// Optional feature macro: LUT_ARB_RR_EN (round-robin instead of fixed priority).
module lut_and_arbiter
    import lut_arb_pkg::*;
#(
    parameter int WIDTH = lut_arb_pkg::WIDTH
) (
    input  logic             clock0,
    input  logic             reset,
    lut_and_arbiter_if.slave bus
);

    logic [NREQ-1:0] grant;
    logic            accept;
    s1_payload_t     payload_d;
    s1_payload_t     s1_q;
    logic            s1_valid_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic            rsp_result_q;

    lut_arb_rr u_arb (
`ifdef LUT_ARB_RR_EN
        .clk   (clock0),
`endif
        .rst   (reset),
        .valid (bus.req_valid),
        .grant (grant)
    );

    assign bus.req_ready  = grant;
    assign accept         = |(bus.req_valid & grant);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;

    // Grant is one-hot, so a single select bit picks the winning operands.
    always_comb begin
        payload_d                  = '0;
        payload_d.data[WIDTH-1:0]  = grant[1] ? bus.req_data1 : bus.req_data0;
        payload_d.mask[WIDTH-1:0]  = grant[1] ? bus.req_mask1 : bus.req_mask0;
        payload_d.id               = grant[1];
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) s1_q <= payload_d;
            rsp_valid_q <= '0;
            // Result only updates with a response, so it holds between pulses.
            if (s1_valid_q) begin
                rsp_valid_q[s1_q.id] <= 1'b1;
                rsp_result_q         <= masked_and(s1_q.data, s1_q.mask);
            end
        end
    end

endmodule

// File: tb/tb_lut_and_arbiter.sv
// Directed bench for lut_and_arbiter: grants, 2-cycle response timing, mask edge cases, reset.
// Build with or without LUT_ARB_RR_EN; contention expectations follow the macro.
module tb_lut_and_arbiter;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [2:0] exp_q[$];
    logic       last_res;

    lut_and_arbiter_if #(.WIDTH(8)) bus ();

    lut_and_arbiter #(.WIDTH(8)) dut (
        .clock0 (clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] m0,
                         input logic [7:0] d1, input logic [7:0] m1);
        bus.req_valid = v;
        bus.req_data0 = d0;
        bus.req_mask0 = m0;
        bus.req_data1 = d1;
        bus.req_mask1 = m1;
    endtask

    // One cycle: drive, check mid-cycle, advance to just after the next rising edge.
    task automatic step(input string tag, input logic [1:0] v,
                        input logic [7:0] d0, input logic [7:0] m0,
                        input logic [7:0] d1, input logic [7:0] m1,
                        input logic [1:0] exp_ready, input logic exp_res);
        logic [2:0] e;
        drive(v, d0, m0, d1, m1);
        #4;
        check_val({tag, "/ready"}, {14'd0, bus.req_ready}, {14'd0, exp_ready});
        e = exp_q.pop_front();
        check_val({tag, "/rsp_valid"}, {14'd0, bus.rsp_valid}, {14'd0, e[2:1]});
        if (e[2:1] != 2'b00) last_res = e[0];
        check_val({tag, "/rsp_result"}, {15'd0, bus.rsp_result}, {15'd0, last_res});
        exp_q.push_back({exp_ready, exp_res});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
    endtask

    // Registered outputs are only checked after the first reset edge has been seen.
    task automatic apply_reset(input string tag, input int cycles, input logic [1:0] v);
        reset = 1'b1;
        drive(v, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        for (int i = 0; i < cycles; i++) begin
            #4;
            check_val({tag, "/ready"}, {14'd0, bus.req_ready}, 16'd0);
            if (i > 0) begin
                check_val({tag, "/rsp_valid"}, {14'd0, bus.rsp_valid}, 16'd0);
                check_val({tag, "/rsp_result"}, {15'd0, bus.rsp_result}, 16'd0);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        last_res = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        last_res = 1'b0;
        reset    = 1'b1;
        drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;

        apply_reset("reset_hold", 3, 2'b11);
        step("first_grant",  2'b11, 8'hFF, 8'h3F, 8'h00, 8'hFF, 2'b01, 1'b1);
        step("req0_fb",      2'b01, 8'hFB, 8'h3F, 8'h00, 8'h00, 2'b01, 1'b0);
        idle("drain_a");
        idle("drain_b");
        idle("hold");
        step("req1_only",    2'b10, 8'h00, 8'h00, 8'h7F, 8'h80, 2'b10, 1'b0);
        step("mask_zero",    2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 1'b1);
        step("mask_c0",      2'b01, 8'hC0, 8'hC0, 8'h00, 8'h00, 2'b01, 1'b1);
        step("req1_low",     2'b10, 8'h00, 8'h00, 8'hF0, 8'h0F, 2'b10, 1'b0);

`ifdef LUT_ARB_RR_EN
        step("contend_0",    2'b11, 8'hAA, 8'hAA, 8'h55, 8'hFF, 2'b01, 1'b1);
        step("contend_1",    2'b11, 8'hAA, 8'hAA, 8'h55, 8'hFF, 2'b10, 1'b0);
        step("contend_2",    2'b11, 8'hAA, 8'hAA, 8'h55, 8'hFF, 2'b01, 1'b1);
        step("contend_3",    2'b11, 8'hAA, 8'hAA, 8'h55, 8'hFF, 2'b10, 1'b0);
`else
        step("contend_0",    2'b11, 8'hAA, 8'hAA, 8'h55, 8'hFF, 2'b01, 1'b1);
        step("contend_1",    2'b11, 8'hAA, 8'hAA, 8'h55, 8'hFF, 2'b01, 1'b1);
        step("contend_2",    2'b11, 8'hAA, 8'hAA, 8'h55, 8'hFF, 2'b01, 1'b1);
        step("contend_3",    2'b11, 8'hAA, 8'hAA, 8'h55, 8'hFF, 2'b01, 1'b1);
`endif
        idle("drain_c");
        idle("drain_d");

        step("flight_req1",  2'b10, 8'h00, 8'h00, 8'hFF, 8'hFF, 2'b10, 1'b1);
        apply_reset("flight_rst", 2, 2'b00);
        idle("flight_chk_a");
        idle("flight_chk_b");
        idle("flight_chk_c");
        step("post_rst",     2'b11, 8'h0F, 8'hF0, 8'hFF, 8'hFF, 2'b01, 1'b0);
        idle("post_drain_a");
        idle("post_drain_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lut_and_arbiter.md
LUT_AND_ARBITER -- requirements
Module: lut_and_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand and mask width in bits (legal range 2..16).
REQ-002 clock0  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid[1:0]  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready[1:0]  output  2  per-requester grant/accept; handshake when req_valid[i] & req_ready[i].
REQ-006 req_data0, req_data1  input  WIDTH each  operand vector per requester.
REQ-007 req_mask0, req_mask1  input  WIDTH each  bit=1 includes the operand bit in the reduction.
REQ-008 rsp_valid[1:0]  output  2  one-cycle response pulse to requester i; no backpressure.
REQ-009 rsp_result  output  1  AND-reduction result, qualified by rsp_valid.

Function
REQ-010 At most one req_ready bit shall be high per cycle, and only for a requester whose req_valid is high.
REQ-011 req_ready shall be combinational from req_valid and the priority pointer; requesters shall not make req_valid depend on req_ready.
REQ-012 With one requester valid, that requester shall be granted in the same cycle.
REQ-013 With both valid, the requester named by the priority pointer shall be granted.
REQ-014 After a grant to requester i, the pointer shall move to the other requester; without a grant it shall hold.
REQ-015 Stage 1: on a handshake, data, mask and requester id shall be registered and s1_valid set; otherwise s1_valid clears.
REQ-016 Stage 2: rsp_result shall be the AND of (data | ~mask) over all WIDTH bits, registered from stage 1.
REQ-017 rsp_valid[id] shall pulse exactly 2 cycles after the accepting edge; the other bit shall stay 0.
REQ-018 Mask all-zero shall yield rsp_result = 1.
REQ-019 Throughput shall be one accepted request per cycle, back-to-back, with no bubbles.
REQ-020 rsp_result shall hold its last value when rsp_valid is 0.

Reset
REQ-021 While reset is high: req_ready = 0, rsp_valid = 0, rsp_result = 0, pipeline valids cleared, pointer = requester 0.
REQ-022 Requests in flight when reset asserts shall be dropped and no response issued for them.
REQ-023 The first grant shall be possible on the first edge after reset deasserts.

Configuration
REQ-024 With macro LUT_ARB_RR_EN defined, arbitration shall be round-robin (REQ-013/014).
REQ-025 Without LUT_ARB_RR_EN, requester 0 shall have fixed priority and the pointer register shall not exist.

Structure
REQ-026 Package lut_arb_pkg shall hold the WIDTH default, NREQ = 2, the requester-id typedef and the stage-1 payload struct typedef.
REQ-027 Arbitration shall be a sub-module lut_arb_rr (valid in, one-hot grant out, pointer state inside); the datapath pipeline stays in the top.

Verification
REQ-028 Reset: hold reset 3 cycles with req_valid = 2'b11 -> req_ready = 0, rsp_valid = 0 throughout; first grant goes to requester 0 after release.
REQ-029 Single request: req0 data = 8'hFF, mask = 8'h3F -> rsp_valid = 2'b01 two cycles later, rsp_result = 1; data = 8'hFB, same mask -> result 0.
REQ-030 Contention (RR_EN): both valid for 4 cycles -> grants 0, 1, 0, 1; responses alternate 2 cycles later.
REQ-031 Fixed priority (no RR_EN): both valid for 4 cycles -> req0 granted every cycle, req1 never.
REQ-032 Edge mask: mask = 8'h00, data = 8'h00 -> rsp_result = 1; mask = 8'hC0, data = 8'hC0 -> 1.
REQ-033 Reset mid-flight: accept req1, assert reset the next cycle -> no rsp_valid is ever produced for it.
